// File: rtl/tlu_trigger_emulator.sv
// EUDET TLU trigger-side emulator: issues triggers, follows the DUT BUSY handshake,
// serializes the trigger number on DUT-supplied TLU_CLOCK and issues TLU_RESET pulses.
`timescale 1ns/1ps
module tlu_trigger_emulator #(
  parameter int DATA_WIDTH        = 15,
  parameter int TRIGGER_PULSE_LEN = 4,
  parameter int RESET_PULSE_LEN   = 8,
  parameter int BUSY_TIMEOUT      = 65535
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            MODE,
  input  logic                  TRIGGER_REQ,
  input  logic                  RESET_REQ,
  input  logic                  TLU_BUSY,
  input  logic                  TLU_CLOCK,
  output logic                  TLU_TRIGGER,
  output logic                  TLU_RESET,
  output logic                  READY,
  output logic [DATA_WIDTH-1:0] TRIGGER_NUMBER,
  output logic [7:0]            TIMEOUT_COUNT,
  output logic [7:0]            SKIPPED_COUNT
);

  localparam int MAXP = (TRIGGER_PULSE_LEN > RESET_PULSE_LEN) ? TRIGGER_PULSE_LEN : RESET_PULSE_LEN;
  localparam int MAXC = (MAXP > BUSY_TIMEOUT) ? MAXP : BUSY_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TP_LAST = CW'(TRIGGER_PULSE_LEN - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(RESET_PULSE_LEN - 1);
  localparam logic [CW-1:0] BT_LAST = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_WAIT_BUSY, S_SHIFT, S_WAIT_IDLE, S_RST_PULSE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_number;
  logic [7:0]            r_timeouts;
  logic [7:0]            r_skipped;
  logic                  r_trig;
  logic                  r_tlu_reset;
  logic                  r_ready;
  logic                  r_rst_pend;
  logic [1:0]            r_busy_sync;
  logic [1:0]            r_clk_sync;
  logic                  r_clk_q;

  logic w_busy;
  logic w_clk_rise;
  logic w_pend_nxt;
  logic w_trig_skip;

  // BUSY and TLU_CLOCK come from the DUT's clock domain
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_busy_sync <= '0;
      r_clk_sync  <= '0;
      r_clk_q     <= 1'b0;
    end else begin
      r_busy_sync <= {r_busy_sync[0], TLU_BUSY};
      r_clk_sync  <= {r_clk_sync[0], TLU_CLOCK};
      r_clk_q     <= r_clk_sync[1];
    end
  end

  assign w_busy      = r_busy_sync[1];
  assign w_clk_rise  = r_clk_sync[1] & ~r_clk_q;
  assign w_pend_nxt  = r_rst_pend | RESET_REQ;
  assign w_trig_skip = TRIGGER_REQ & ((r_state != S_IDLE) | w_pend_nxt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_number    <= '0;
      r_timeouts  <= '0;
      r_skipped   <= '0;
      r_trig      <= 1'b0;
      r_tlu_reset <= 1'b0;
      r_ready     <= 1'b0;
      r_rst_pend  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (RESET_REQ) r_rst_pend <= 1'b1;
      if (w_trig_skip && r_skipped != 8'hFF) r_skipped <= r_skipped + 8'd1;

      case (r_state)
        S_IDLE: begin
          // a pending reset wins over a same-cycle trigger request
          if (w_pend_nxt) begin
            r_state     <= S_RST_PULSE;
            r_tlu_reset <= 1'b1;
            r_number    <= '0;
            r_cnt       <= '0;
            r_rst_pend  <= 1'b0;
          end else if (TRIGGER_REQ && MODE != 2'b00) begin
            r_mode  <= MODE;
            r_shift <= r_number;
            r_trig  <= 1'b1;
            r_cnt   <= '0;
            r_state <= (MODE == 2'b01) ? S_PULSE : S_WAIT_BUSY;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_PULSE: begin
          if (r_cnt == TP_LAST) begin
            r_trig   <= 1'b0;
            r_number <= r_number + DATA_WIDTH'(1);
            r_state  <= S_IDLE;
            r_ready  <= ~w_pend_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_BUSY: begin
          if (w_busy) begin
            r_trig  <= 1'b0;
            r_state <= (r_mode == 2'b11) ? S_SHIFT : S_WAIT_IDLE;
          end else if (r_cnt == BT_LAST) begin
            r_trig  <= 1'b0;
            if (r_timeouts != 8'hFF) r_timeouts <= r_timeouts + 8'd1;
            r_state <= S_IDLE;
            r_ready <= ~w_pend_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_SHIFT: begin
          // DUT may stop clocking early; BUSY release always ends the transfer
          if (!w_busy) begin
            r_trig   <= 1'b0;
            r_number <= r_number + DATA_WIDTH'(1);
            r_state  <= S_IDLE;
            r_ready  <= ~w_pend_nxt;
          end else if (w_clk_rise) begin
            r_trig  <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end

        S_WAIT_IDLE: begin
          if (!w_busy) begin
            r_number <= r_number + DATA_WIDTH'(1);
            r_state  <= S_IDLE;
            r_ready  <= ~w_pend_nxt;
          end
        end

        S_RST_PULSE: begin
          if (r_cnt == RP_LAST) begin
            r_tlu_reset <= 1'b0;
            r_state     <= S_IDLE;
            r_ready     <= ~w_pend_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign TLU_TRIGGER    = r_trig;
  assign TLU_RESET      = r_tlu_reset;
  assign READY          = r_ready;
  assign TRIGGER_NUMBER = r_number;
  assign TIMEOUT_COUNT  = r_timeouts;
  assign SKIPPED_COUNT  = r_skipped;

endmodule

// File: doc/tlu_trigger_emulator.md
Name: tlu_trigger_emulator

Overview:
- Emulates the EUDET TLU end of the trigger interface, for lab and bench operation without a real TLU.
- On a trigger request it drives TLU_TRIGGER and honours the DUT BUSY handshake.
- In data-handshake mode it serializes the current trigger number onto TLU_TRIGGER, clocked by the DUT-supplied TLU_CLOCK.
- It also issues TLU_RESET pulses and keeps trigger, timeout and skip counters for readout.

Parameters:
- DATA_WIDTH, 15: trigger number bits shifted out (EUDET TLU number width).
- TRIGGER_PULSE_LEN, 4: TLU_TRIGGER high time in CLK cycles in no-handshake mode.
- RESET_PULSE_LEN, 8: TLU_RESET high time in CLK cycles.
- BUSY_TIMEOUT, 65535: CLK cycles to wait for BUSY assertion before abort.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- MODE  in  2  00 disabled, 01 no handshake, 10 simple handshake, 11 trigger data handshake.
- TRIGGER_REQ  in  1  single-cycle request to issue one trigger.
- RESET_REQ  in  1  single-cycle request to issue TLU_RESET and clear the trigger number.
- TLU_BUSY  in  1  DUT busy, asynchronous.
- TLU_CLOCK  in  1  DUT serial clock, asynchronous.
- TLU_TRIGGER  out  1  trigger / serial data line to the DUT.
- TLU_RESET  out  1  reset line to the DUT.
- READY  out  1  high in IDLE with no reset pending.
- TRIGGER_NUMBER  out  DATA_WIDTH  number the next trigger will carry.
- TIMEOUT_COUNT  out  8  saturating count of BUSY timeouts.
- SKIPPED_COUNT  out  8  saturating count of rejected TRIGGER_REQ.

Behaviour:
- Reset values: TLU_TRIGGER=0, TLU_RESET=0, READY=0 during reset and 1 in the first cycle after, TRIGGER_NUMBER=0, both counts=0, state IDLE.
- Input synchronization: TLU_BUSY and TLU_CLOCK pass through 2-FF synchronizers.
- Clock edge detection: rising-edge detect on synchronized TLU_CLOCK. TLU_CLOCK period must be at least 6 CLK cycles.
- Mode latch: MODE is sampled when a trigger is accepted and held to the end of the transaction. Mid-transaction MODE changes take effect on the next trigger.
- IDLE:
  - TRIGGER_REQ with MODE=00 is ignored and nothing is counted.
  - Otherwise the accepted request latches shift_reg <= TRIGGER_NUMBER and sets TLU_TRIGGER=1 on the next edge. Latency is 1 cycle.
  - Next state: PULSE if MODE=01, WAIT_BUSY if MODE is 10 or 11.
- PULSE:
  - TLU_TRIGGER held high for exactly TRIGGER_PULSE_LEN cycles; BUSY is ignored.
  - Then TLU_TRIGGER=0, TRIGGER_NUMBER+1, go to IDLE.
- WAIT_BUSY:
  - Synchronized BUSY=1 sets TLU_TRIGGER=0. Go to SHIFT if the latched mode is 11, else WAIT_IDLE.
  - After BUSY_TIMEOUT cycles without BUSY: TLU_TRIGGER=0, TIMEOUT_COUNT+1 (saturating at 255), TRIGGER_NUMBER unchanged, go to IDLE.
- SHIFT:
  - Each TLU_CLOCK rising edge: TLU_TRIGGER <= shift_reg[0], shift_reg >>= 1, zero-filled. LSB goes out first.
  - After DATA_WIDTH edges, further edges drive 0.
  - BUSY falling in SHIFT: TLU_TRIGGER=0, TRIGGER_NUMBER+1, go to IDLE. A short read by the DUT is not an error.
- WAIT_IDLE: BUSY falling gives TRIGGER_NUMBER+1 and IDLE. There is no timeout on BUSY stuck high.
- TRIGGER_NUMBER wraps from 2^DATA_WIDTH-1 to 0.
- SKIPPED_COUNT: TRIGGER_REQ in any state other than IDLE, or with a reset pending, increments it (saturating) and is otherwise dropped.
- RESET_REQ:
  - Sets a pending flag in any state, without aborting a running transaction.
  - In IDLE with the flag set: TLU_RESET=1 for RESET_PULSE_LEN cycles (state RST_PULSE), TRIGGER_NUMBER=0, flag cleared, return to IDLE.
  - A pending reset has priority over a same-cycle TRIGGER_REQ; that TRIGGER_REQ counts as skipped.
- READY=0 outside IDLE or while a reset is pending.
- Asynchronous RESET mid-transaction: all outputs go to their reset values immediately and any transaction in progress is lost.

Test Plan:
- MODE=01, TRIGGER_REQ ->
  - TLU_TRIGGER high exactly 4 cycles starting 1 cycle after the request.
  - TRIGGER_NUMBER 0->1.
  - BUSY ignored.
- MODE=10, BUSY raised 10 cycles after TLU_TRIGGER, dropped 20 cycles later ->
  - TLU_TRIGGER falls within 3 cycles of BUSY rising.
  - READY returns within 3 cycles of BUSY falling.
  - TRIGGER_NUMBER=1.
- MODE=11, TRIGGER_NUMBER preset to 0x2A5B via 0x2A5B triggers, DUT clocks 15 edges (period 10 cycles) ->
  - Bits sampled on TLU_CLOCK falling edges read 0x2A5B, LSB first.
  - 16th and 17th edges give 0.
- MODE=10, BUSY never asserted, BUSY_TIMEOUT overridden to 100 ->
  - TLU_TRIGGER drops at cycle 101.
  - TIMEOUT_COUNT=1, TRIGGER_NUMBER unchanged.
- TRIGGER_REQ during WAIT_IDLE, then RESET_REQ together with TRIGGER_REQ in the same IDLE cycle ->
  - SKIPPED_COUNT=2.
  - TLU_RESET high 8 cycles.
  - TRIGGER_NUMBER=0.
- Counter wrap and async reset:
  - Counter wrap: TRIGGER_NUMBER=0x7FFF plus one MODE=01 trigger -> TRIGGER_NUMBER=0.
  - Async reset: RESET asserted mid-SHIFT -> TLU_TRIGGER=0 in the same cycle, state IDLE, counts cleared.
